// File: rtl/mem_pkg.sv
// Shared types for the single-port memory request/response protocol
// and the BIST initiator that drives it.
package mem_pkg;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_typ_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WDRAIN,
    READ,
    RDRAIN,
    DONE
  } bist_state_e;

endpackage

// File: rtl/mem_os_tracker.sv
// Outstanding-request counter: +1 per accepted request,
// -1 per consumed response, with full/empty flags.
module mem_os_tracker #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [CW-1:0] r_cnt;

  // simultaneous inc and dec cancel out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      unique case ({inc_i, dec_i})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign cnt_o   = r_cnt;
  assign full_o  = (r_cnt == CW'(MAX_OUTSTANDING));
  assign empty_o = (r_cnt == '0);

endmodule

// File: rtl/mem_bist_initiator.sv
// BIST master: writes seed+k over a wrapping address window,
// reads it back and reports pass, error count and first bad address.
module mem_bist_initiator
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_SIZE        = 128,
  parameter int MAX_OUTSTANDING = 2,
  localparam int ADDR_WIDTH     = $clog2(MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  req_val_o,
  output logic                  req_typ_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [DATA_WIDTH-1:0] req_data_o,
  input  logic                  req_rdy_i,
  input  logic                  rsp_val_i,
  input  logic [DATA_WIDTH-1:0] rsp_data_i,
  output logic                  rsp_rdy_o
);

  localparam int AW = ADDR_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  bist_state_e     r_state;
  logic [AW-1:0]   r_base;
  logic [LW-1:0]   r_len;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [LW-1:0]   r_iss;
  logic [LW-1:0]   r_chk;
  logic [LW-1:0]   r_err_cnt;
  logic [AW-1:0]   r_first_err;
  logic            r_pass;
  logic            r_busy;
  logic            r_done;

  logic [CW-1:0]   w_os;
  logic            w_full;
  logic            w_empty;
  logic            w_active;
  logic            w_is_wr;
  logic            w_req_val;
  logic            w_req_fire;
  logic            w_rsp_fire;
  logic            w_last_iss;
  logic            w_chk_fire;
  logic            w_mis;
  logic [DATA_WIDTH-1:0] w_exp;

  mem_os_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CW             (CW)
  ) u_os (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_req_fire),
    .dec_i  (w_rsp_fire),
    .cnt_o  (w_os),
    .full_o (w_full),
    .empty_o(w_empty)
  );

  // request side is a pure function of state and issue index,
  // so it cannot change while stalled
  assign w_active   = (r_state == WRITE) || (r_state == READ);
  assign w_is_wr    = (r_state == WRITE);
  assign w_req_val  = w_active && !w_full && (r_iss < r_len);
  assign w_req_fire = w_req_val && req_rdy_i;
  assign w_rsp_fire = rsp_val_i && !w_empty;
  assign w_last_iss = w_req_fire && (r_iss == r_len - 1'b1);

  // reads are only issued after writes drain, so any response
  // seen in the read phases belongs to a read
  assign w_chk_fire = w_rsp_fire &&
                      ((r_state == READ) || (r_state == RDRAIN));
  assign w_exp      = r_seed + DATA_WIDTH'(r_chk);
  assign w_mis      = w_chk_fire && (rsp_data_i != w_exp);

  assign req_val_o  = w_req_val;
  assign req_typ_o  = w_is_wr ? REQ_WR : REQ_RD;
  assign req_addr_o = r_base + r_iss[AW-1:0];
  assign req_data_o = w_is_wr ? (r_seed + DATA_WIDTH'(r_iss))
                              : '0;
  assign rsp_rdy_o  = !w_empty;

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err;

  // main sequencer with registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_seed      <= '0;
      r_iss       <= '0;
      r_chk       <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_chk_fire) begin
        r_chk <= r_chk + 1'b1;
        if (w_mis) begin
          r_err_cnt <= r_err_cnt + 1'b1;
          if (r_err_cnt == '0)
            r_first_err <= r_base + r_chk[AW-1:0];
        end
      end
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_base      <= base_addr_i;
            r_len       <= len_i;
            r_seed      <= seed_i;
            r_iss       <= '0;
            r_chk       <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
            if (len_i == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= WRITE;
              r_busy  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_req_fire) r_iss <= r_iss + 1'b1;
          if (w_last_iss) r_state <= WDRAIN;
        end
        WDRAIN: begin
          if (w_empty) begin
            r_iss   <= '0;
            r_state <= READ;
          end
        end
        READ: begin
          if (w_req_fire) r_iss <= r_iss + 1'b1;
          if (w_last_iss) r_state <= RDRAIN;
        end
        RDRAIN: begin
          if (w_empty && (r_chk == r_len)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (r_err_cnt == '0);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Directed bench for mem_bist_initiator with a behavioural
// memory offering stalls, response delay and read corruption.
module tb_mem_bist_initiator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [6:0]  base_addr_i = '0;
  logic [7:0]  len_i = '0;
  logic [31:0] seed_i = '0;
  logic        busy_o, done_o, pass_o;
  logic [7:0]  err_cnt_o;
  logic [6:0]  first_err_addr_o;
  logic        req_val_o, req_typ_o;
  logic [6:0]  req_addr_o;
  logic [31:0] req_data_o;
  logic        req_rdy_i = 1'b0;
  logic        rsp_val_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        rsp_rdy_o;

  int total = 0;
  int bad = 0;

  mem_bist_initiator dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .base_addr_i     (base_addr_i),
    .len_i           (len_i),
    .seed_i          (seed_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .pass_o          (pass_o),
    .err_cnt_o       (err_cnt_o),
    .first_err_addr_o(first_err_addr_o),
    .req_val_o       (req_val_o),
    .req_typ_o       (req_typ_o),
    .req_addr_o      (req_addr_o),
    .req_data_o      (req_data_o),
    .req_rdy_i       (req_rdy_i),
    .rsp_val_i       (rsp_val_i),
    .rsp_data_i      (rsp_data_i),
    .rsp_rdy_o       (rsp_rdy_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] mem [128];
  logic [31:0] q_data [$];
  int          q_time [$];
  bit          lg_typ [$];
  int          lg_addr [$];
  logic [31:0] lg_data [$];
  int cyc = 0;
  int os_tb = 0;
  int max_os = 0;
  int stab_err = 0;
  int rdy_pct = 100;
  int max_dly = 0;
  int corrupt_addr = -1;
  bit          p_stall = 0;
  logic        p_typ;
  logic [6:0]  p_addr;
  logic [31:0] p_data;

  initial for (int i = 0; i < 128; i++) mem[i] = '0;

  // memory model: decides at negedge what fires at the next posedge
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      q_data.delete();
      q_time.delete();
      os_tb = 0;
      req_rdy_i = 1'b0;
      rsp_val_i = 1'b0;
      rsp_data_i = '0;
      p_stall = 0;
    end else begin
      req_rdy_i = ($urandom_range(99) < rdy_pct);
      if (q_data.size() > 0 && q_time[0] <= cyc) begin
        rsp_val_i = 1'b1;
        rsp_data_i = q_data[0];
      end else begin
        rsp_val_i = 1'b0;
        rsp_data_i = '0;
      end
      if (p_stall && (!req_val_o || req_typ_o !== p_typ ||
          req_addr_o !== p_addr || req_data_o !== p_data))
        stab_err++;
      if (rsp_val_i && rsp_rdy_o) begin
        void'(q_data.pop_front());
        void'(q_time.pop_front());
        os_tb--;
      end
      if (req_val_o && req_rdy_i) begin
        lg_typ.push_back(req_typ_o);
        lg_addr.push_back(int'(req_addr_o));
        lg_data.push_back(req_data_o);
        if (req_typ_o) begin
          mem[req_addr_o] = req_data_o;
          q_data.push_back(32'h0);
        end else if (int'(req_addr_o) == corrupt_addr) begin
          q_data.push_back(mem[req_addr_o] ^ 32'h1);
        end else begin
          q_data.push_back(mem[req_addr_o]);
        end
        q_time.push_back(cyc + 1 + int'($urandom_range(max_dly)));
        os_tb++;
        p_stall = 0;
      end else if (req_val_o) begin
        p_stall = 1;
        p_typ = req_typ_o;
        p_addr = req_addr_o;
        p_data = req_data_o;
      end else begin
        p_stall = 0;
      end
      if (os_tb > max_os) max_os = os_tb;
    end
  end

  task automatic run_bist(input int base, input int len,
                          input logic [31:0] seed,
                          output int cycles, output bit to,
                          output bit saw_busy);
    lg_typ.delete();
    lg_addr.delete();
    lg_data.delete();
    max_os = 0;
    stab_err = 0;
    @(negedge clk_i);
    base_addr_i = 7'(base);
    len_i = 8'(len);
    seed_i = seed;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    saw_busy = busy_o;
    base_addr_i = '0;
    len_i = '0;
    seed_i = '0;
    cycles = 1;
    to = 1;
    while (cycles < 5000) begin
      if (done_o) begin
        to = 0;
        break;
      end
      @(negedge clk_i);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({busy_o, done_o, pass_o, req_val_o, rsp_rdy_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=00000",
               {busy_o, done_o, pass_o, req_val_o, rsp_rdy_o});
    end
    total++;
    if (err_cnt_o !== 8'd0 || first_err_addr_o !== 7'd0) begin
      bad++;
      $display("FAIL reset_err got=%0d/%0d want=0/0",
               err_cnt_o, first_err_addr_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    int c; bit to; bit sb; int e;
    rdy_pct = 100; max_dly = 0; corrupt_addr = -1;
    run_bist(0, 4, 32'h100, c, to, sb);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout"); end
    total++;
    if (!sb) begin bad++; $display("FAIL basic_busy got=0 want=1"); end
    total++;
    if (pass_o !== 1'b1 || err_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL basic_result pass=%b err=%0d want 1/0",
               pass_o, err_cnt_o);
    end
    e = 0;
    if (lg_typ.size() != 8) e++;
    else for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        if (lg_typ[i] != 1'b1 || lg_addr[i] != i ||
            lg_data[i] !== 32'h100 + 32'(i)) e++;
      end else begin
        if (lg_typ[i] != 1'b0 || lg_addr[i] != i - 4 ||
            lg_data[i] !== 32'h0) e++;
      end
    end
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL basic_traffic n=%0d bad_entries=%0d want 8/0",
               lg_typ.size(), e);
    end
    total++;
    if (mem[3] !== 32'h103) begin
      bad++;
      $display("FAIL basic_mem3 got=%h want=00000103", mem[3]);
    end
    total++;
    if (c > 14) begin
      bad++;
      $display("FAIL basic_throughput cycles=%0d want<=14", c);
    end
    @(negedge clk_i);
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || pass_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_pulse done=%b busy=%b pass=%b want 0/0/1",
               done_o, busy_o, pass_o);
    end
  endtask

  task automatic test_wrap();
    int c; bit to; bit sb; int e;
    int exp_a [4];
    exp_a = '{126, 127, 0, 1};
    run_bist(126, 4, 32'h0, c, to, sb);
    e = 0;
    if (lg_addr.size() != 8) e++;
    else for (int i = 0; i < 8; i++)
      if (lg_addr[i] != exp_a[i % 4]) e++;
    total++;
    if (e != 0 || to) begin
      bad++;
      $display("FAIL wrap_addr n=%0d bad=%0d to=%0d want 8/0/0",
               lg_addr.size(), e, to);
    end
    total++;
    if (pass_o !== 1'b1) begin
      bad++;
      $display("FAIL wrap_pass got=%b want=1", pass_o);
    end
  endtask

  task automatic test_stall();
    int c; bit to; bit sb;
    rdy_pct = 50; max_dly = 3;
    run_bist(10, 16, 32'hdeadbeef, c, to, sb);
    total++;
    if (to || pass_o !== 1'b1 || err_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL stall_result to=%0d pass=%b err=%0d want 0/1/0",
               to, pass_o, err_cnt_o);
    end
    total++;
    if (stab_err != 0) begin
      bad++;
      $display("FAIL stall_stable changes=%0d want=0", stab_err);
    end
    total++;
    if (max_os > 2) begin
      bad++;
      $display("FAIL stall_os max=%0d want<=2", max_os);
    end
    total++;
    if (lg_typ.size() != 32) begin
      bad++;
      $display("FAIL stall_count got=%0d want=32", lg_typ.size());
    end
    rdy_pct = 100; max_dly = 0;
  endtask

  task automatic test_corrupt();
    int c; bit to; bit sb;
    corrupt_addr = 5;
    run_bist(3, 8, 32'h55, c, to, sb);
    corrupt_addr = -1;
    total++;
    if (to || err_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL corrupt_cnt got=%0d to=%0d want=1", err_cnt_o, to);
    end
    total++;
    if (first_err_addr_o !== 7'd5) begin
      bad++;
      $display("FAIL corrupt_addr got=%0d want=5", first_err_addr_o);
    end
    total++;
    if (pass_o !== 1'b0) begin
      bad++;
      $display("FAIL corrupt_pass got=%b want=0", pass_o);
    end
  endtask

  task automatic test_len0();
    int c; bit to; bit sb;
    run_bist(9, 0, 32'h1, c, to, sb);
    total++;
    if (to || c > 2) begin
      bad++;
      $display("FAIL len0_latency cycles=%0d to=%0d want<=2", c, to);
    end
    total++;
    if (pass_o !== 1'b1 || err_cnt_o !== 8'd0 ||
        first_err_addr_o !== 7'd0) begin
      bad++;
      $display("FAIL len0_result pass=%b err=%0d first=%0d want 1/0/0",
               pass_o, err_cnt_o, first_err_addr_o);
    end
    @(negedge clk_i);
    total++;
    if (lg_typ.size() != 0) begin
      bad++;
      $display("FAIL len0_traffic got=%0d want=0", lg_typ.size());
    end
  endtask

  task automatic test_full();
    int c; bit to; bit sb; int e;
    logic [31:0] sd;
    sd = 32'ha5a5_0000;
    run_bist(7, 128, sd, c, to, sb);
    total++;
    if (to || pass_o !== 1'b1 || lg_typ.size() != 256) begin
      bad++;
      $display("FAIL full_result to=%0d pass=%b n=%0d want 0/1/256",
               to, pass_o, lg_typ.size());
    end
    e = 0;
    for (int k = 0; k < 128; k++)
      if (mem[(7 + k) % 128] !== sd + 32'(k)) e++;
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL full_mem bad_words=%0d want=0", e);
    end
  endtask

  task automatic test_back_to_back();
    int c; bit to; bit sb; int n;
    lg_typ.delete();
    @(negedge clk_i);
    base_addr_i = 7'd0; len_i = 8'd64; seed_i = 32'h77;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 0;
    while (n < 1000 && !(lg_typ.size() > 0 &&
           lg_typ[lg_typ.size()-1] == 1'b0)) begin
      @(negedge clk_i);
      n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL midrst_reach_read timeout=%0d", n);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if ({busy_o, done_o, pass_o, req_val_o, rsp_rdy_o} !== 5'b0 ||
        err_cnt_o !== 8'd0 || first_err_addr_o !== 7'd0) begin
      bad++;
      $display("FAIL midrst_outputs ctl=%b err=%0d first=%0d want 0",
               {busy_o, done_o, pass_o, req_val_o, rsp_rdy_o},
               err_cnt_o, first_err_addr_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_bist(0, 2, 32'h9, c, to, sb);
    total++;
    if (to || pass_o !== 1'b1 || err_cnt_o !== 8'd0 ||
        lg_typ.size() != 4) begin
      bad++;
      $display("FAIL midrst_retest to=%0d pass=%b err=%0d n=%0d",
               to, pass_o, err_cnt_o, lg_typ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_corrupt();
    test_len0();
    test_full();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
